ps2_kbd_rx: RTL and testbench

Host-side PS/2 keyboard frame receiver. It sits directly downstream of the SPI/IO controller's PS/2 keyboard emulation output (`ps2_kbd_clk` / `ps2_kbd_data`). It deserialises 11-bit device-to-host frames, validates start, parity and stop bits, and folds the `E0`/`F0` prefix bytes into decoded key events. Events reach core logic through a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_evt_fifo.sv | 67 ++++++
 rtl/ps2_kbd_rx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_pkg : shared types and constants for the PS/2 keyboard receiver
// Rev 1.0
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ps2_state_e;

  // "release" is a reserved word, so the release flag is carried as rel.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_key_evt_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_evt_fifo : synchronous FIFO, wrap-around pointers plus occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
module ps2_evt_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (DEPTH_BITS+1)'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is taken when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + DEPTH_BITS'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
    end
    count_d = count_q + (DEPTH_BITS+1)'(do_push) - (DEPTH_BITS+1)'(do_pop);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_kbd_rx : PS/2 keyboard frame receiver; PS2_KBD_RX_FIFO_EN selects FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT   = 20000,
  parameter int FIFO_BITS = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err,
  output logic       overrun
);

  localparam int                WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  if (FIFO_BITS < 1 || FIFO_BITS > 8) begin : g_bad_fifo_bits
    $error("ps2_kbd_rx: FIFO_BITS out of range");
  end

  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic fall_q, fall_d, data_smp_q, data_smp_d;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    fall_d     = clk_prev_q & ~clk_s2_q;
    data_smp_d = dat_s2_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fall_q     <= 1'b0;
      data_smp_q <= 1'b1;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      fall_q     <= fall_d;
      data_smp_q <= data_smp_d;
    end
  end

  ps2_state_e   state_q;
  logic [3:0]   bit_cnt_q;
  logic [7:0]   shreg_q;
  logic         par_q, ext_pend_q, rel_pend_q, push_q, frame_err_q;
  logic [WD_W-1:0] wdog_q;
  ps2_key_evt_t evt_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'h00;
      par_q       <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wdog_q      <= '0;
      evt_q       <= '0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall_q || state_q != SHIFT) wdog_q <= '0;
      else                            wdog_q <= wdog_q + WD_W'(1);
      case (state_q)
        IDLE: begin
          if (fall_q) begin
            if (!data_smp_q) begin
              state_q   <= SHIFT;
              bit_cnt_q <= 4'd1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (fall_q) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q <= 4'd8) begin
              shreg_q <= {data_smp_q, shreg_q[7:1]};
            end else if (bit_cnt_q == 4'd9) begin
              par_q <= data_smp_q;
            end else begin
              state_q <= IDLE;
              if ((^{shreg_q, par_q}) && data_smp_q) begin
                if (shreg_q == PS2_PFX_EXT) begin
                  ext_pend_q <= 1'b1;
                end else if (shreg_q == PS2_PFX_REL) begin
                  rel_pend_q <= 1'b1;
                end else begin
                  push_q     <= 1'b1;
                  evt_q.ext  <= ext_pend_q;
                  evt_q.rel  <= rel_pend_q;
                  evt_q.code <= shreg_q;
                  ext_pend_q <= 1'b0;
                  rel_pend_q <= 1'b0;
                end
              end else begin
                frame_err_q <= 1'b1;
                ext_pend_q  <= 1'b0;
                rel_pend_q  <= 1'b0;
              end
            end
          end else if (wdog_q == WD_LAST) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            ext_pend_q  <= 1'b0;
            rel_pend_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic pop, store_full, overrun_q, overrun_d;
  assign pop = key_valid & key_ready;

`ifdef PS2_KBD_RX_FIFO_EN
  logic         fifo_empty;
  ps2_key_evt_t head;

  ps2_evt_fifo #(
    .WIDTH      ($bits(ps2_key_evt_t)),
    .DEPTH_BITS (FIFO_BITS)
  ) u_evt_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push_q),
    .din     (evt_q),
    .pop     (pop),
    .dout    (head),
    .empty   (fifo_empty),
    .full    (store_full)
  );

  assign key_valid   = ~fifo_empty;
  assign key_code    = head.code;
  assign key_ext     = head.ext;
  assign key_release = head.rel;
`else
  logic         hold_vld_q, hold_vld_d;
  ps2_key_evt_t hold_q, hold_d;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    if (pop) hold_vld_d = 1'b0;
    if (push_q && (!hold_vld_q || pop)) begin
      hold_vld_d = 1'b1;
      hold_d     = evt_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

  assign store_full  = hold_vld_q;
  assign key_valid   = hold_vld_q;
  assign key_code    = hold_q.code;
  assign key_ext     = hold_q.ext;
  assign key_release = hold_q.rel;
`endif

  assign overrun_d = push_q & store_full & ~pop;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ps2_kbd_rx : frame table plus corner sequences, events checked from a queue
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ps2_kbd_rx;

  localparam int TO   = 300;
  localparam int HALF = 10;

  logic       clk_sys   = 1'b0;
  logic       reset_n   = 1'b0;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic       key_ready = 1'b0;
  logic       key_valid, key_ext, key_release, frame_err, overrun;
  logic [7:0] key_code;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;
  logic err_prev = 1'b0;
  logic ovr_prev = 1'b0;
  logic [9:0] sb[$];

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         evt;
    logic [7:0] code;
    bit         ext;
    bit         rel;
    int         errs;
  } vec_t;

  vec_t tbl[13];

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_rx #(.TIMEOUT(TO), .FIFO_BITS(2)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pulses counted, accepted events compared against the scoreboard.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (frame_err) begin
        err_cnt++;
        check("frame_err_width", {31'd0, err_prev}, 0);
      end
      if (overrun) begin
        ovr_cnt++;
        check("overrun_width", {31'd0, ovr_prev}, 0);
      end
      if (key_valid && key_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got %0h expected none",
                   {key_ext, key_release, key_code});
        end else begin
          logic [9:0] exp;
          exp = sb.pop_front();
          check("event", {22'd0, key_ext, key_release, key_code}, {22'd0, exp});
        end
      end
    end
    err_prev = frame_err;
    ovr_prev = overrun;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic ps2_bit(logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; lat measures the stop-bit-to-valid delay.
  task automatic send(logic [7:0] b, bit bad, int nbits, bit lat);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (lat && i == 10) begin
        ps2_data = f[i];
        tick(HALF);
        ps2_clk = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
          tick(1);
          if (k == 4) check("latency_before", {31'd0, key_valid}, 0);
          if (k == 5) check("latency_at5",    {31'd0, key_valid}, 1);
        end
        ps2_clk = 1'b1;
      end else begin
        ps2_bit(f[i]);
      end
    end
    ps2_data = 1'b1;
    tick(3 * HALF);
  endtask

  initial begin
    int e0, o0;
    tbl[0]  = '{8'h1C, 0, 1, 8'h1C, 0, 0, 0};
    tbl[1]  = '{8'hE0, 0, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0};
    tbl[3]  = '{8'h75, 0, 1, 8'h75, 1, 1, 0};
    tbl[4]  = '{8'h1C, 0, 1, 8'h1C, 0, 0, 0};
    tbl[5]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0};
    tbl[6]  = '{8'h2A, 1, 0, 8'h00, 0, 0, 1};
    tbl[7]  = '{8'hE0, 0, 0, 8'h00, 0, 0, 0};
    tbl[8]  = '{8'h74, 0, 1, 8'h74, 1, 0, 0};
    tbl[9]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0};
    tbl[10] = '{8'h1C, 0, 1, 8'h1C, 0, 1, 0};
    tbl[11] = '{8'hE1, 0, 1, 8'hE1, 0, 0, 0};
    tbl[12] = '{8'hE0, 0, 0, 8'h00, 0, 0, 0};

    tick(3);
    check("rst_key_valid",   {31'd0, key_valid},   0);
    check("rst_key_code",    {24'd0, key_code},    0);
    check("rst_key_ext",     {31'd0, key_ext},     0);
    check("rst_key_release", {31'd0, key_release}, 0);
    check("rst_frame_err",   {31'd0, frame_err},   0);
    check("rst_overrun",     {31'd0, overrun},     0);
    reset_n = 1'b1;
    tick(5);

    key_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      e0 = err_cnt;
      if (tbl[i].evt) sb.push_back({tbl[i].ext, tbl[i].rel, tbl[i].code});
      send(tbl[i].b, tbl[i].bad, 11, i == 0);
      check($sformatf("tbl%0d_frame_err", i), err_cnt - e0, tbl[i].errs);
    end
    // Trailing E0 is resolved by this 7C.
    sb.push_back({1'b1, 1'b0, 8'h7C});
    send(8'h7C, 0, 11, 0);
    tick(5);
    check("tbl_drained", sb.size(), 0);

    e0 = err_cnt;
    send(8'h55, 0, 5, 0);
    tick(TO + 20);
    check("timeout_err", err_cnt - e0, 1);
    sb.push_back({1'b0, 1'b0, 8'h16});
    send(8'h16, 0, 11, 0);
    tick(5);
    check("timeout_recover_drained", sb.size(), 0);
    check("timeout_recover_err", err_cnt - e0, 1);

    key_ready = 1'b0;
    o0 = ovr_cnt;
    for (int c = 0; c < 5; c++) begin
`ifdef PS2_KBD_RX_FIFO_EN
      if (c < 4) sb.push_back({2'b00, 8'h11 + 8'(c)});
`else
      if (c < 1) sb.push_back({2'b00, 8'h11 + 8'(c)});
`endif
      send(8'h11 + 8'(c), 0, 11, 0);
    end
    check("stall_valid", {31'd0, key_valid}, 1);
    check("stall_code",  {24'd0, key_code},  32'h11);
`ifdef PS2_KBD_RX_FIFO_EN
    check("overrun_count", ovr_cnt - o0, 1);
`else
    check("overrun_count", ovr_cnt - o0, 4);
`endif
    key_ready = 1'b1;
    tick(10);
    check("overrun_drained", sb.size(), 0);
    check("drain_valid_low", {31'd0, key_valid}, 0);

    key_ready = 1'b0;
    send(8'h3C, 0, 11, 0);
    check("pre_reset_valid", {31'd0, key_valid}, 1);
    send(8'h5A, 0, 7, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_key_valid", {31'd0, key_valid}, 0);
    check("midrst_key_code",  {24'd0, key_code},  0);
    check("midrst_overrun",   {31'd0, overrun},   0);
    check("midrst_frame_err", {31'd0, frame_err}, 0);
    tick(3);
    reset_n = 1'b1;
    tick(5);
    key_ready = 1'b1;
    e0 = err_cnt;
    sb.push_back({1'b0, 1'b0, 8'h4D});
    send(8'h4D, 0, 11, 0);
    tick(5);
    check("postrst_drained", sb.size(), 0);
    check("postrst_err", err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
